// File: rtl/sync_rx.sv
`timescale 1ns/1ps
// Frame-synchronous serial receiver: synchronises an external sample clock, sync and data,
// locks onto frame sync, tracks sample index / frame count and packs 16-bit words.
module sync_rx #(
    parameter int SPF      = 512,
    parameter int SP_NBIT  = 9,
    parameter int MISS_MAX = 8
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               sync_in,
    input  logic               spclk_in,
    input  logic               data_in,
    output logic               sp_stb,
    output logic [SP_NBIT-1:0] sp_idx,
    output logic               frame_start,
    output logic               locked,
    output logic [15:0]        frame_cnt,
    output logic               word_vd,
    output logic [15:0]        word,
    output logic               err_len,
    output logic [7:0]         err_cnt
);

    typedef enum logic [1:0] {HUNT = 2'd0, LOCK = 2'd1, FLY = 2'd2} state_t;

    localparam logic [SP_NBIT-1:0] IDX_LAST = SP_NBIT'(SPF - 1);
    localparam logic [7:0]         MISS_LIM = 8'(MISS_MAX);

    logic [1:0]         r_sync_ff;
    logic [1:0]         r_spclk_ff;
    logic [1:0]         r_data_ff;
    logic               r_spclk_d;
    logic               r_cap_vld;
    logic               r_cap_sync;
    logic               r_cap_data;
    logic               r_smp_vld;
    logic               r_smp_sync_ev;
    logic               r_smp_data;
    logic               r_prev_sync;
    state_t             r_state;
    logic [7:0]         r_miss;
    logic [15:0]        r_shift;

    logic               w_fall;
    logic [SP_NBIT-1:0] w_idx_nxt;
    logic               w_wrap;
    logic [7:0]         w_miss_nxt;
    logic [7:0]         w_err_nxt;
    logic               w_drop;
    logic               w_take;
    logic [SP_NBIT-1:0] w_new_idx;
    logic [15:0]        w_word_nxt;

    // Synchronisers run regardless of en; only the event path is gated.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_ff  <= '0;
            r_spclk_ff <= '0;
            r_data_ff  <= '0;
            r_spclk_d  <= 1'b0;
        end else begin
            r_sync_ff  <= {r_sync_ff[0], sync_in};
            r_spclk_ff <= {r_spclk_ff[0], spclk_in};
            r_data_ff  <= {r_data_ff[0], data_in};
            r_spclk_d  <= r_spclk_ff[1];
        end
    end

    assign w_fall = r_spclk_d & ~r_spclk_ff[1];

    // Capture stage, then sync-edge detection stage; FSM registers outputs one edge later.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_vld     <= 1'b0;
            r_cap_sync    <= 1'b0;
            r_cap_data    <= 1'b0;
            r_smp_vld     <= 1'b0;
            r_smp_sync_ev <= 1'b0;
            r_smp_data    <= 1'b0;
            r_prev_sync   <= 1'b0;
        end else begin
            r_cap_vld <= en & w_fall;
            r_smp_vld <= en & r_cap_vld;
            if (w_fall) begin
                r_cap_sync <= r_sync_ff[1];
                r_cap_data <= r_data_ff[1];
            end
            if (!en) begin
                r_prev_sync <= 1'b0;
            end else if (r_cap_vld) begin
                r_smp_sync_ev <= r_cap_sync & ~r_prev_sync;
                r_prev_sync   <= r_cap_sync;
                r_smp_data    <= r_cap_data;
            end
        end
    end

    always_comb begin
        w_idx_nxt  = (sp_idx == IDX_LAST) ? '0 : sp_idx + 1'b1;
        w_wrap     = (w_idx_nxt == '0);
        w_miss_nxt = r_miss + 8'd1;
        w_err_nxt  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        w_drop     = ~r_smp_sync_ev & w_wrap & (w_miss_nxt >= MISS_LIM);
        w_take     = 1'b0;
        if (en && r_smp_vld) begin
            w_take = (r_state == HUNT) ? r_smp_sync_ev : ~w_drop;
        end
        w_new_idx  = (r_smp_sync_ev || r_state == HUNT) ? '0 : w_idx_nxt;
        w_word_nxt = {r_shift[14:0], r_smp_data};
    end

    // The word bit position is sp_idx[3:0], so a resync to index 0 drops any partial word.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HUNT;
            r_miss      <= '0;
            r_shift     <= '0;
            sp_stb      <= 1'b0;
            sp_idx      <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            frame_cnt   <= '0;
            word_vd     <= 1'b0;
            word        <= '0;
            err_len     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            sp_stb      <= 1'b0;
            frame_start <= 1'b0;
            word_vd     <= 1'b0;
            err_len     <= 1'b0;
            if (!en) begin
                r_state   <= HUNT;
                locked    <= 1'b0;
                r_miss    <= '0;
                sp_idx    <= '0;
                frame_cnt <= '0;
                err_cnt   <= '0;
            end else if (r_smp_vld) begin
                case (r_state)
                    HUNT: begin
                        if (r_smp_sync_ev) begin
                            r_state     <= LOCK;
                            locked      <= 1'b1;
                            r_miss      <= '0;
                            frame_cnt   <= '0;
                            frame_start <= 1'b1;
                        end
                    end
                    default: begin
                        if (r_smp_sync_ev) begin
                            if (!w_wrap) begin
                                err_len <= 1'b1;
                                err_cnt <= w_err_nxt;
                            end
                            r_state     <= LOCK;
                            r_miss      <= '0;
                            frame_cnt   <= frame_cnt + 16'd1;
                            frame_start <= 1'b1;
                        end else if (w_wrap) begin
                            if (w_drop) begin
                                r_state <= HUNT;
                                locked  <= 1'b0;
                                r_miss  <= '0;
                            end else begin
                                r_state     <= FLY;
                                r_miss      <= w_miss_nxt;
                                frame_cnt   <= frame_cnt + 16'd1;
                                frame_start <= 1'b1;
                            end
                        end
                    end
                endcase
                if (w_take) begin
                    sp_stb  <= 1'b1;
                    sp_idx  <= w_new_idx;
                    r_shift <= w_word_nxt;
                    if (w_new_idx[3:0] == 4'hF) begin
                        word_vd <= 1'b1;
                        word    <= w_word_nxt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_rx.sv
`timescale 1ns/1ps
// Bench for sync_rx: scenario table plus hand sequences, every strobe checked against a
// sample-level reference model through an expected queue.
module tb_sync_rx;

    localparam int SPF      = 32;
    localparam int SP_NBIT  = 9;
    localparam int MISS_MAX = 8;
    localparam int EW       = 53;

    logic               mclk = 1'b0;
    logic               reset_n = 1'b0;
    logic               en = 1'b0;
    logic               sync_in = 1'b0;
    logic               spclk_in = 1'b1;
    logic               data_in = 1'b0;
    logic               sp_stb;
    logic [SP_NBIT-1:0] sp_idx;
    logic               frame_start;
    logic               locked;
    logic [15:0]        frame_cnt;
    logic               word_vd;
    logic [15:0]        word;
    logic               err_len;
    logic [7:0]         err_cnt;

    sync_rx #(.SPF(SPF), .SP_NBIT(SP_NBIT), .MISS_MAX(MISS_MAX)) dut (
        .mclk(mclk), .reset_n(reset_n), .en(en), .sync_in(sync_in), .spclk_in(spclk_in),
        .data_in(data_in), .sp_stb(sp_stb), .sp_idx(sp_idx), .frame_start(frame_start),
        .locked(locked), .frame_cnt(frame_cnt), .word_vd(word_vd), .word(word),
        .err_len(err_len), .err_cnt(err_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 mclk = ~mclk;

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [15:0]   got_words[$];
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_obs;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic lk, input logic el, input logic [7:0] ec,
                                           input logic vd, input logic [15:0] w, input logic fs,
                                           input logic [15:0] fc, input logic [8:0] ix);
        return {lk, el, ec, vd, w, fs, fc, ix};
    endfunction

    function automatic logic [63:0] obs_all();
        return 64'({sp_stb, sp_idx, frame_start, locked, frame_cnt, word_vd, word, err_len, err_cnt});
    endfunction

    always @(posedge mclk) begin
        #1;
        if (sp_stb) begin
            if (exp_q.size() == 0) begin
                check("stb_unexpected", 64'(sp_stb), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_obs = pack(locked, err_len, err_cnt, word_vd, word_vd ? word : 16'h0,
                               frame_start, frame_cnt, sp_idx);
                check("sample", 64'(mon_obs), 64'(mon_exp));
            end
            if (word_vd) got_words.push_back(word);
        end else if (frame_start || word_vd || err_len) begin
            check("stray_pulse", 64'({frame_start, word_vd, err_len}), 64'd0);
        end
    end

    // ---------------- reference model (per accepted sample) ----------------
    bit m_locked;
    bit m_prev;
    int m_idx, m_fcnt, m_ecnt, m_miss;
    bit m_bits[$];

    task automatic model_clear();
        m_locked = 0; m_prev = 0; m_idx = 0; m_fcnt = 0; m_ecnt = 0; m_miss = 0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit s, input bit d);
        bit ev, emit, fs, el, vd;
        logic [15:0] w;
        int nxt;
        ev = s && !m_prev;
        m_prev = s;
        emit = 0; fs = 0; el = 0; vd = 0; w = '0;
        if (!m_locked) begin
            if (ev) begin
                m_locked = 1; m_idx = 0; m_fcnt = 0; m_miss = 0; emit = 1; fs = 1;
            end
        end else begin
            nxt = (m_idx + 1) % SPF;
            if (ev) begin
                if (nxt != 0) begin
                    el = 1;
                    if (m_ecnt < 255) m_ecnt++;
                end
                m_idx = 0; m_fcnt = (m_fcnt + 1) % 65536; m_miss = 0; emit = 1; fs = 1;
            end else if (nxt == 0) begin
                m_miss++;
                if (m_miss >= MISS_MAX) begin
                    m_locked = 0; m_miss = 0;
                end else begin
                    m_idx = 0; m_fcnt = (m_fcnt + 1) % 65536; emit = 1; fs = 1;
                end
            end else begin
                m_idx = nxt; emit = 1;
            end
        end
        if (emit) begin
            if (m_idx == 0) m_bits.delete();
            m_bits.push_back(d);
            if (m_bits.size() == 16) begin
                vd = 1;
                for (int i = 0; i < 16; i++) w = {w[14:0], m_bits[i]};
                m_bits.delete();
            end
            exp_q.push_back(pack(1'b1, el, 8'(m_ecnt), vd, w, fs, 16'(m_fcnt), 9'(m_idx)));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_sample(input bit s, input bit d, input bit mdl);
        if (mdl) model_step(s, d);
        @(negedge mclk);
        sync_in = s; data_in = d; spclk_in = 1'b1;
        repeat (4) @(negedge mclk);
        spclk_in = 1'b0;
        repeat (3) @(negedge mclk);
    endtask

    task automatic settle();
        repeat (8) @(negedge mclk);
    endtask

    task automatic drain(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge mclk);
        en = 1'b0; sync_in = 1'b0; spclk_in = 1'b1; data_in = 1'b0; reset_n = 1'b0;
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;
        model_clear();
        @(negedge mclk);
        en = 1'b1;
        @(negedge mclk);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int frames;
        int sync_mode;   // 0 every frame, 1 superframe, 2 resync at 20, 3 random, 4 every 2nd sample
        int data_mode;   // 0 high for p<30, 1 random
        int exp_fcnt;    // -1: take from model
        int exp_ecnt;
        int exp_locked;
    } vec_t;

    vec_t vecs[5];

    function automatic bit gen_sync(input int mode, input int n);
        int f, p;
        f = n / SPF;
        p = n % SPF;
        case (mode)
            0: return p == 0;
            1: return (p == 0) && (f < 100 || f == 105);
            2: return n == 0 || n == SPF + 20 || n == 2 * SPF + 20;
            3: return $urandom_range(0, 39) == 0;
            default: return (n % 2) == 0;
        endcase
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        bit s, d;
        do_reset();
        got_words.delete();
        for (int n = 0; n < v.frames * SPF; n++) begin
            s = gen_sync(v.sync_mode, n);
            d = (v.data_mode == 0) ? ((n % SPF) < 30) : 1'($urandom_range(0, 1));
            send_sample(s, d, 1'b1);
        end
        settle();
        check($sformatf("vec%0d_frame_cnt", k), 64'(frame_cnt),
              64'((v.exp_fcnt >= 0) ? v.exp_fcnt : m_fcnt));
        check($sformatf("vec%0d_err_cnt", k), 64'(err_cnt),
              64'((v.exp_ecnt >= 0) ? v.exp_ecnt : m_ecnt));
        check($sformatf("vec%0d_locked", k), 64'(locked),
              64'((v.exp_locked >= 0) ? v.exp_locked : int'(m_locked)));
        drain($sformatf("vec%0d_drain", k));
    endtask

    // ---------------- main ----------------
    initial begin
        vecs[0] = '{3,   0, 0, 2,   0,   1};
        vecs[1] = '{114, 1, 1, 112, 0,   0};
        vecs[2] = '{4,   2, 1, 4,   1,   1};
        vecs[3] = '{8,   3, 1, -1,  -1,  -1};
        vecs[4] = '{19,  4, 1, 303, 255, 1};

        // Reset held with inputs toggling: every output stays 0.
        reset_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge mclk);
            sync_in  = 1'($urandom_range(0, 1));
            spclk_in = 1'($urandom_range(0, 1));
            data_in  = 1'($urandom_range(0, 1));
            en       = 1'($urandom_range(0, 1));
            @(posedge mclk); #1;
            check("reset_hold_outputs", obs_all(), 64'd0);
        end
        @(negedge mclk);
        sync_in = 1'b0; en = 1'b1; reset_n = 1'b1;
        model_clear();
        for (int i = 0; i < 20; i++) send_sample(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        settle();
        check("no_sync_locked", 64'(locked), 64'd0);
        drain("no_sync_drain");

        // Latency: strobe appears on the 4th edge after the edge that first sees spclk low.
        do_reset();
        model_step(1'b1, 1'b1);
        @(negedge mclk);
        sync_in = 1'b1; data_in = 1'b1; spclk_in = 1'b1;
        repeat (4) @(negedge mclk);
        spclk_in = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(posedge mclk); #1;
            check($sformatf("latency_edge%0d", k), 64'(sp_stb), 64'(k == 4));
        end
        settle();
        drain("latency_drain");

        // Scenario table.
        for (int k = 0; k < 5; k++) begin
            run_vec(k, vecs[k]);
            if (k == 0) begin
                check("nominal_word_count", 64'(got_words.size()), 64'd6);
                for (int i = 0; i < got_words.size(); i++)
                    check($sformatf("nominal_word%0d", i), 64'(got_words[i]),
                          64'((i % 2 == 0) ? 16'hFFFF : 16'hFFFC));
            end
        end

        // en dropped mid-frame, plus an spclk edge while disabled.
        do_reset();
        for (int n = 0; n <= 20; n++) send_sample(n == 0, 1'($urandom_range(0, 1)), 1'b1);
        settle();
        @(negedge mclk);
        en = 1'b0;
        model_clear();
        @(posedge mclk); #1;
        check("en_drop_locked", 64'(locked), 64'd0);
        check("en_drop_frame_cnt", 64'(frame_cnt), 64'd0);
        check("en_drop_err_cnt", 64'(err_cnt), 64'd0);
        send_sample(1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge mclk);
        en = 1'b1;
        for (int i = 0; i < 20; i++) send_sample(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        settle();
        check("en_relock_needs_sync", 64'(locked), 64'd0);
        send_sample(1'b1, 1'b1, 1'b1);
        settle();
        check("en_relock_locked", 64'(locked), 64'd1);
        drain("en_drain");

        // reset_n dropped mid-frame.
        for (int n = 0; n < 20; n++) send_sample(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        settle();
        @(negedge mclk);
        reset_n = 1'b0;
        #1;
        check("reset_mid_outputs", obs_all(), 64'd0);
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        model_clear();
        for (int i = 0; i < 10; i++) send_sample(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        settle();
        check("reset_relock_needs_sync", 64'(locked), 64'd0);
        send_sample(1'b1, 1'b0, 1'b1);
        settle();
        check("reset_relock_locked", 64'(locked), 64'd1);
        drain("reset_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_rx.md
SYNC_RX -- requirements
Module: sync_rx

Interface
REQ-001 Parameter SPF, default 512: samples per frame; SHALL satisfy 16 <= SPF <= 2^SP_NBIT and be a multiple of 16.
REQ-002 Parameter SP_NBIT, default 9: width of the sample index.
REQ-003 Parameter MISS_MAX, default 8: number of consecutive frames with no sync before lock is lost.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 mclk  in  1  system clock, 100 MHz; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 en  in  1  receive enable, synchronous to mclk.
REQ-008 sync_in  in  1  frame sync from the external pin, asynchronous; high for one sample period.
REQ-009 spclk_in  in  1  sample clock from the external pin, asynchronous, nominally 200 kHz.
REQ-010 data_in  in  1  serial data bit, asynchronous.
REQ-011 sp_stb  out  1  one-cycle pulse, one per accepted sample.
REQ-012 sp_idx  out  SP_NBIT  index of the sample just taken; valid while sp_stb is high.
REQ-013 frame_start  out  1  one-cycle pulse, coincident with sp_stb when sp_idx = 0.
REQ-014 locked  out  1  high in LOCK and FLY states.
REQ-015 frame_cnt  out  16  frame counter; wraps from 0xFFFF to 0.
REQ-016 word_vd  out  1  one-cycle pulse when word is valid.
REQ-017 word  out  16  16 packed data bits, MSB is the earliest bit.
REQ-018 err_len  out  1  one-cycle pulse on a sync at an unexpected position.
REQ-019 err_cnt  out  8  error count; saturates at 255.

Function
REQ-020 Input synchronisation:
- sync_in, spclk_in and data_in SHALL each pass through a 2-flop synchroniser.
- The sample event SHALL be the synchronised falling edge of spclk_in (mid-sample).
- At the sample event, the synchronised sync and data SHALL be captured.
REQ-021 Output latency: sp_stb and all associated outputs SHALL assert exactly 4 mclk edges after the edge that first captures spclk_in low.
REQ-022 Sync detection: a sync event SHALL be a captured sync = 1 whose previous captured sync = 0.
REQ-023 State machine: states HUNT, LOCK, FLY; the state SHALL be HUNT after reset.
REQ-024 HUNT:
- No sp_stb or word_vd SHALL be produced.
- On a sync event: sp_idx = 0, frame_cnt = 0, frame_start pulses, go to LOCK.
REQ-025 LOCK and FLY, sample index: each sample SHALL produce sp_stb, with sp_idx incrementing and wrapping SPF-1 -> 0.
REQ-026 LOCK and FLY, frame count: every wrap to 0 SHALL pulse frame_start and increment frame_cnt.
REQ-027 Sync where the expected index is 0: go to LOCK and clear the miss counter; no error.
REQ-028 Sync where the expected index is not 0:
- err_len pulses and err_cnt increments (saturating at 255).
- The sync sample SHALL become sp_idx = 0, with frame_start and frame_cnt increment.
- State becomes LOCK and the miss counter clears.
REQ-029 Wrap to index 0 with no sync:
- The miss counter SHALL increment.
- If the miss counter reaches MISS_MAX, go to HUNT and drop locked; that sample SHALL NOT produce sp_stb.
- Otherwise go to FLY; frame_start still pulses.
REQ-030 Data packing:
- Each sp_stb sample SHALL shift the captured data bit into the word.
- The bit counter SHALL reset at sp_idx = 0.
- word_vd SHALL pulse with the 16th bit (sp_idx mod 16 = 15), giving SPF/16 words per frame.
REQ-031 A resync under REQ-028 SHALL discard the partial word.
REQ-032 en = 0 SHALL synchronously force HUNT, clear the miss counter, bit counter, frame_cnt and err_cnt, and suppress all pulses; synchroniser flops keep running.
REQ-033 An spclk edge arriving while en = 0 SHALL NOT be processed after en rises.

Reset
REQ-034 reset_n low SHALL asynchronously clear:
- all outputs to 0;
- all synchroniser flops to 0;
- all counters to 0;
- the state to HUNT.
REQ-035 Release of reset SHALL be synchronised to mclk by the integrating level; the block SHALL detect no spurious edge on the first cycle after release.

Verification
REQ-036 Reset held with inputs toggling -> all outputs 0 throughout; after release with no sync -> locked = 0, no sp_stb.
REQ-037 Nominal stream, 512 samples per frame, sync on sample 0, 3 frames ->
- locked = 1 from the first sync;
- frame_start every 512 sp_stb;
- frame_cnt 0, 1, 2;
- err_cnt = 0;
- sp_stb latency 4 mclk.
REQ-038 data_in high for samples 0..269, low for samples 270..511 -> words 0..15 = 0xFFFF, word 16 = 0xFFFC, words 17..31 = 0x0000.
REQ-039 Superframe of 100 synced frames then 5 with no sync ->
- FLY during the 5 missing frames with locked = 1 and frame_cnt still incrementing;
- return to LOCK at frame 105;
- a further 8 missing frames -> locked falls at the 8th wrap.
REQ-040 Sync injected at expected index 300 -> err_len pulse, err_cnt = 1, sp_idx = 0 on that sample, partial word dropped, next word aligned.
REQ-041 reset_n or en dropped mid-frame (sp_idx = 200) -> immediate clear; relock requires a new sync.
